// File: rtl/swt16_pkg.sv
// Shared widths, ALU opcode encodings and execute-stage FSM states for the swt16 pipeline.
package swt16_pkg;
    localparam int DMEM_ADDR_WIDTH = 12;
    localparam int DMEM_WORD_WIDTH = 16;
    localparam int IALU_WORD_WIDTH = 16;
    localparam int ALU_OP_WIDTH    = 4;
    localparam int PC_WIDTH        = 12;
    localparam int PMEM_WORD_WIDTH = 16;
    localparam int REG_IDX_WIDTH   = 4;
    localparam int MUL_CYCLES      = 16;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SHL   = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SHR   = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_PASSB = 4'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL   = 4'd11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, low half of the product kept.
module ex_mul_seq
    import swt16_pkg::*;
#(
    parameter int W      = IALU_WORD_WIDTH,
    parameter int CYCLES = MUL_CYCLES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         flush,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product,
    output state_t       state
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  acc_step;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = BUSY;
            BUSY: if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final step is folded in combinationally so the product is ready at the finishing edge.
    assign acc_step = acc + (b_sh[0] ? a_sh : '0);
    assign busy     = (state == BUSY);
    assign done     = busy && (cnt == LAST);
    assign product  = acc_step;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                a_sh <= a;
                b_sh <= b;
                acc  <= '0;
                cnt  <= '0;
            end else if (busy) begin
                acc  <= acc_step;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= done ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ex_stage.sv
// swt16 execute stage: single-cycle ALU plus sequenced MUL, registering everything MEM consumes.
module ex_stage
    import swt16_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_flush,
    input  logic [ALU_OP_WIDTH-1:0]    in_alu_op,
    input  logic [IALU_WORD_WIDTH-1:0] in_op_a,
    input  logic [IALU_WORD_WIDTH-1:0] in_op_b,
    input  logic [DMEM_WORD_WIDTH-1:0] in_store_word,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    output logic                       out_stall,
    output logic                       out_act_load_dmem,
    output logic                       out_act_store_dmem,
    output logic                       out_act_write_res_to_reg,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic                       out_res_valid_MEM,
    output state_t                     dbg_state
);
    logic                       mul_start;
    logic                       mul_busy;
    logic                       mul_done;
    logic [IALU_WORD_WIDTH-1:0] mul_product;
    logic                       fire_single;
    logic [IALU_WORD_WIDTH-1:0] alu_res;

    // Instruction context held while the multiplier runs.
    logic                       lat_load;
    logic                       lat_store;
    logic                       lat_write;
    logic [PMEM_WORD_WIDTH-1:0] lat_instr;
    logic [PC_WIDTH-1:0]        lat_pc;
    logic [REG_IDX_WIDTH-1:0]   lat_idx;
    logic [DMEM_WORD_WIDTH-1:0] lat_word;

    assign mul_start   = !in_flush && !mul_busy && in_valid && (in_alu_op == ALU_MUL);
    assign fire_single = !in_flush && !mul_busy && in_valid && (in_alu_op != ALU_MUL);
    assign out_stall   = !reset && !in_flush && (mul_start || (mul_busy && !mul_done));

    ex_mul_seq #(.W(IALU_WORD_WIDTH), .CYCLES(MUL_CYCLES)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .flush   (in_flush),
        .a       (in_op_a),
        .b       (in_op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product),
        .state   (dbg_state)
    );

    always_comb begin
        alu_res = '0;
        case (in_alu_op)
            ALU_ADD:   alu_res = in_op_a + in_op_b;
            ALU_SUB:   alu_res = in_op_a - in_op_b;
            ALU_AND:   alu_res = in_op_a & in_op_b;
            ALU_OR:    alu_res = in_op_a | in_op_b;
            ALU_XOR:   alu_res = in_op_a ^ in_op_b;
            ALU_SHL:   alu_res = in_op_a << in_op_b[3:0];
            ALU_SHR:   alu_res = in_op_a >> in_op_b[3:0];
            ALU_SRA:   alu_res = $signed(in_op_a) >>> in_op_b[3:0];
            ALU_SLT:   alu_res = {{(IALU_WORD_WIDTH-1){1'b0}}, ($signed(in_op_a) < $signed(in_op_b))};
            ALU_SLTU:  alu_res = {{(IALU_WORD_WIDTH-1){1'b0}}, (in_op_a < in_op_b)};
            ALU_PASSB: alu_res = in_op_b;
            default:   alu_res = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            {lat_load, lat_store, lat_write} <= '0;
            lat_instr <= '0;
            lat_pc    <= '0;
            lat_idx   <= '0;
            lat_word  <= '0;
        end else if (mul_start) begin
            lat_load  <= in_act_load_dmem;
            lat_store <= in_act_store_dmem;
            lat_write <= in_act_write_res_to_reg;
            lat_instr <= in_instr;
            lat_pc    <= in_pc;
            lat_idx   <= in_res_reg_idx;
            lat_word  <= in_store_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || in_flush || !(fire_single || mul_done)) begin
            out_act_load_dmem        <= 1'b0;
            out_act_store_dmem       <= 1'b0;
            out_act_write_res_to_reg <= 1'b0;
            out_instr                <= '0;
            out_pc                   <= '0;
            out_res                  <= '0;
            out_mem_rd_addr          <= '0;
            out_mem_wr_addr          <= '0;
            out_mem_wr_word          <= '0;
            out_res_reg_idx          <= '0;
            out_res_valid_MEM        <= 1'b0;
        end else if (mul_done) begin
            out_act_load_dmem        <= lat_load;
            out_act_store_dmem       <= lat_store;
            out_act_write_res_to_reg <= lat_write;
            out_instr                <= lat_instr;
            out_pc                   <= lat_pc;
            out_res                  <= mul_product;
            out_mem_rd_addr          <= mul_product[DMEM_ADDR_WIDTH-1:0];
            out_mem_wr_addr          <= mul_product[DMEM_ADDR_WIDTH-1:0];
            out_mem_wr_word          <= lat_word;
            out_res_reg_idx          <= lat_idx;
            out_res_valid_MEM        <= lat_write && !lat_load;
        end else begin
            out_act_load_dmem        <= in_act_load_dmem;
            out_act_store_dmem       <= in_act_store_dmem;
            out_act_write_res_to_reg <= in_act_write_res_to_reg;
            out_instr                <= in_instr;
            out_pc                   <= in_pc;
            out_res                  <= alu_res;
            out_mem_rd_addr          <= alu_res[DMEM_ADDR_WIDTH-1:0];
            out_mem_wr_addr          <= alu_res[DMEM_ADDR_WIDTH-1:0];
            out_mem_wr_word          <= in_store_word;
            out_res_reg_idx          <= in_res_reg_idx;
            out_res_valid_MEM        <= in_act_write_res_to_reg && !in_act_load_dmem;
        end
    end
endmodule
